// File: rtl/event_trace_player.sv
// Trace buffer that replays timestamped events as per-channel input/new_input pulses for a monitor.
// Optional TRACE_LOOP_EN adds a `loop` input and a `laps` counter for continuous replay.
module event_trace_player #(
    parameter int NUM_CH  = 1,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 16,
    parameter int DELAY_W = 32,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [DELAY_W-1:0]       ld_delay,
    input  logic [NUM_CH-1:0]        ld_mask,
    input  logic [NUM_CH*DATA_W-1:0] ld_data,
    input  logic                     clr,
    input  logic                     start,
    input  logic                     abort,
`ifdef TRACE_LOOP_EN
    input  logic                     loop,
    output logic [15:0]              laps,
`endif
    output logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        new_in,
    output logic                     busy,
    output logic                     done,
    output logic [CW-1:0]            count,
    output logic [CW-1:0]            played
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEMD = 1 << AW;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [CW-1:0]             count_q, count_d;
    logic [CW-1:0]             played_q, played_d;
    logic [CW-1:0]             ptr_q, ptr_d;
    logic [DELAY_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0]         new_in_q, new_in_d;
    logic [NUM_CH*DATA_W-1:0]  in_data_q, in_data_d;
    logic                      done_q, done_d;
    logic                      busy_q;
`ifdef TRACE_LOOP_EN
    logic [15:0]               laps_q, laps_d;
`endif

    logic [DELAY_W-1:0]        dly_mem  [MEMD];
    logic [NUM_CH-1:0]         mask_mem [MEMD];
    logic [NUM_CH*DATA_W-1:0]  data_mem [MEMD];

    logic                      idle_like_s;
    logic                      load_s;
    logic                      last_s;
    logic                      loop_s;
    logic [AW-1:0]             cur_idx_s;
    logic [AW-1:0]             nxt_idx_s;

    function automatic logic [NUM_CH*DATA_W-1:0] mask_lanes(
        input logic [NUM_CH-1:0]        m,
        input logic [NUM_CH*DATA_W-1:0] d
    );
        logic [NUM_CH*DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (m[k]) begin
                r[k*DATA_W +: DATA_W] = d[k*DATA_W +: DATA_W];
            end else begin
                r[k*DATA_W +: DATA_W] = '0;
            end
        end
        return r;
    endfunction

`ifdef TRACE_LOOP_EN
    assign loop_s = loop;
    assign laps   = laps_q;
`else
    assign loop_s = 1'b0;
`endif

    assign idle_like_s = (state_q != S_RUN);
    assign ld_ready    = idle_like_s && (count_q < DEPTH_C) && !start && !clr;
    assign load_s      = ld_valid && ld_ready;
    assign last_s      = (ptr_q == (count_q - CW'(1)));
    assign cur_idx_s   = ptr_q[AW-1:0];
    assign nxt_idx_s   = ptr_q[AW-1:0] + AW'(1);

    assign in_data = in_data_q;
    assign new_in  = new_in_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign count   = count_q;
    assign played  = played_q;

    // Trace buffer write port; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (load_s) begin
            dly_mem[count_q[AW-1:0]]  <= ld_delay;
            mask_mem[count_q[AW-1:0]] <= ld_mask;
            data_mem[count_q[AW-1:0]] <= ld_data;
        end
    end

    // Next-state: abort beats clr, clr beats start, start beats load, then replay stepping.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        played_d  = played_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        new_in_d  = '0;
        in_data_d = en ? '0 : in_data_q;
`ifdef TRACE_LOOP_EN
        laps_d    = laps_q;
`endif
        if (abort) begin
            state_d   = S_IDLE;
            in_data_d = '0;
        end else if (idle_like_s && clr) begin
            state_d  = S_IDLE;
            count_d  = '0;
            played_d = '0;
            done_d   = 1'b0;
        end else if (idle_like_s && start && en) begin
            if (count_q == '0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                state_d  = S_RUN;
                ptr_d    = '0;
                cnt_d    = dly_mem[0];
                played_d = '0;
                done_d   = 1'b0;
            end
        end else if (load_s) begin
            state_d = S_IDLE;
            count_d = count_q + CW'(1);
            done_d  = 1'b0;
        end else if ((state_q == S_RUN) && en) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DELAY_W'(1);
            end else begin
                new_in_d  = mask_mem[cur_idx_s];
                in_data_d = mask_lanes(mask_mem[cur_idx_s], data_mem[cur_idx_s]);
                played_d  = played_q + CW'(1);
                if (last_s && loop_s) begin
                    ptr_d    = '0;
                    cnt_d    = dly_mem[0];
                    played_d = '0;
`ifdef TRACE_LOOP_EN
                    laps_d   = laps_q + 16'd1;
`endif
                end else if (last_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + CW'(1);
                    cnt_d = dly_mem[nxt_idx_s];
                end
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            played_q  <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            new_in_q  <= '0;
            in_data_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef TRACE_LOOP_EN
            laps_q    <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            played_q  <= played_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            new_in_q  <= new_in_d;
            in_data_q <= in_data_d;
            done_q    <= done_d;
            busy_q    <= (state_d == S_RUN);
`ifdef TRACE_LOOP_EN
            laps_q    <= laps_d;
`endif
        end
    end

endmodule

// File: tb/tb_event_trace_player.sv
// Bench for event_trace_player: an event-schedule model (prefix sums of enabled edges) checked every cycle.
module tb_event_trace_player;

    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 16;
    localparam int DELAY_W = 8;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int DW      = NUM_CH * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [DELAY_W-1:0] ld_delay = '0;
    logic [NUM_CH-1:0] ld_mask = '0;
    logic [DW-1:0]     ld_data = '0;
    logic              clr = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [DW-1:0]     in_data;
    logic [NUM_CH-1:0] new_in;
    logic              busy;
    logic              done;
    logic [CW-1:0]     count;
    logic [CW-1:0]     played;
`ifdef TRACE_LOOP_EN
    logic              loop = 1'b0;
    logic [15:0]       laps;
`endif

    event_trace_player #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DELAY_W(DELAY_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_delay(ld_delay),
        .ld_mask(ld_mask), .ld_data(ld_data),
        .clr(clr), .start(start), .abort(abort),
`ifdef TRACE_LOOP_EN
        .loop(loop), .laps(laps),
`endif
        .in_data(in_data), .new_in(new_in), .busy(busy), .done(done),
        .count(count), .played(played)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned       dly;
        logic [NUM_CH-1:0] mask;
        logic [DW-1:0]     data;
    } ent_t;

    ent_t              tr[$];
    bit                m_run;
    bit                m_done;
    int                m_played;
    int                m_e;      // enabled edges since replay (or lap) began
    logic [NUM_CH-1:0] m_new;
    logic [DW-1:0]     m_data;
    int                m_laps;

    function automatic logic [DW-1:0] lanes(input logic [NUM_CH-1:0] m, input logic [DW-1:0] d);
        logic [DW-1:0] keep;
        keep = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (m[k]) keep[k*DATA_W +: DATA_W] = {DATA_W{1'b1}};
        end
        return d & keep;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tr.delete();
            m_run = 1'b0; m_done = 1'b0; m_played = 0; m_e = 0;
            m_new = '0; m_data = '0; m_laps = 0;
        end else begin : step
            bit rdy;
            int hit;
            int sum;
            bit wrap;
            rdy = !m_run && (tr.size() < DEPTH) && !start && !clr;
            m_new = '0;
            if (en) m_data = '0;
            if (abort) begin
                m_run = 1'b0;
                m_data = '0;
            end else if (!m_run && clr) begin
                tr.delete(); m_played = 0; m_done = 1'b0;
            end else if (!m_run && start && en) begin
                if (tr.size() == 0) m_done = 1'b1;
                else begin m_run = 1'b1; m_e = 0; m_played = 0; m_done = 1'b0; end
            end else if (ld_valid && rdy) begin
                tr.push_back('{dly: int'(ld_delay), mask: ld_mask, data: ld_data});
                m_done = 1'b0;
            end else if (m_run && en) begin
                // entry i fires on the enabled edge where the count reaches sum_{j<=i}(delay_j + 1)
                m_e++;
                hit = -1; sum = 0;
                for (int i = 0; i < tr.size(); i++) begin
                    sum += int'(tr[i].dly) + 1;
                    if (sum == m_e) hit = i;
                end
                if (hit >= 0) begin
                    m_new = tr[hit].mask;
                    m_data = lanes(tr[hit].mask, tr[hit].data);
                    m_played = hit + 1;
                    if (hit == tr.size() - 1) begin
                        wrap = 1'b0;
`ifdef TRACE_LOOP_EN
                        wrap = loop;
`endif
                        if (wrap) begin
                            m_e = 0; m_played = 0; m_laps = (m_laps + 1) % 65536;
                        end else begin
                            m_run = 1'b0; m_done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge once out of reset.
    always @(negedge clk) begin
        if (chk_on) begin
            check("new_in", new_in, m_new);
            check("in_data", in_data, m_data);
            check("busy", busy, m_run);
            check("done", done, m_done);
            check("count", count, tr.size());
            check("played", played, m_played);
            check("ld_ready", ld_ready, !m_run && (tr.size() < DEPTH) && !start && !clr);
`ifdef TRACE_LOOP_EN
            check("laps", laps, m_laps);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int d, input logic [NUM_CH-1:0] m, input logic [DW-1:0] dat);
        ld_valid = 1'b1; ld_delay = DELAY_W'(d); ld_mask = m; ld_data = dat;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin tick(); c++; end
        check("run_timeout", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 1'b1;
        tick(); tick();
        check("rst_ld_ready", ld_ready, 1);
        check("rst_new_in", new_in, 0);
        check("rst_in_data", in_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_played", played, 0);
        rst = 1'b1;
        chk_on = 1'b1;
        tick();

        // delays {3,0,0}, data {1,2,3}: pulses at k+4..k+6
        load(3, 2'b01, 32'd1); load(0, 2'b01, 32'd2); load(0, 2'b01, 32'd3);
        pulse_start();
        tick(); tick(); tick();
        check("seq_k3_new", new_in, 0);
        tick();
        check("seq_k4_new", new_in, 2'b01);
        check("seq_k4_data", in_data, 32'd1);
        tick();
        check("seq_k5_data", in_data, 32'd2);
        tick();
        check("seq_k6_data", in_data, 32'd3);
        check("seq_k6_done", done, 1);
        check("seq_k6_played", played, 3);
        tick();
        check("seq_k7_data", in_data, 0);
        check("seq_k7_new", new_in, 0);

        // two-channel mask: only lane 1 passes
        do_clr();
        load(0, 2'b10, {16'hFFFB, 16'd9});
        pulse_start();
        tick();
        check("mask_new", new_in, 2'b10);
        check("mask_data", in_data, {16'hFFFB, 16'h0000});

        // fill the buffer, then a refused 17th load
        do_clr();
        for (int i = 0; i < DEPTH; i++) load($urandom_range(0, 2), 2'($urandom), 32'($urandom));
        check("full_ready", ld_ready, 0);
        load(1, 2'b11, 32'hDEAD_BEEF);
        check("full_count", count, 16);
        pulse_start();
        run_until_idle(200);
        check("full_played", played, 16);
        check("full_done", done, 1);

        // abort mid-wait, then full restart
        do_clr();
        load(10, 2'b01, 32'd7);
        pulse_start();
        tick(); tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_busy", busy, 0);
        for (int i = 0; i < 10; i++) tick();
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        check("restart_k10_new", new_in, 0);
        tick();
        check("restart_k11_new", new_in, 2'b01);
        check("restart_k11_data", in_data, 32'd7);

        // enable stall of 3 cycles delays the pulse by 3
        do_clr();
        load(5, 2'b01, 32'd5);
        pulse_start();
        tick();
        en = 1'b0; tick(); tick(); tick(); en = 1'b1;
        tick(); tick(); tick(); tick();
        check("stall_k8_new", new_in, 0);
        tick();
        check("stall_k9_new", new_in, 2'b01);

        // start together with ld_valid: load refused
        ld_valid = 1'b1; start = 1'b1; ld_delay = 8'd0; ld_mask = 2'b01; ld_data = 32'd4;
        #1;
        check("startld_ready", ld_ready, 0);
        tick();
        ld_valid = 1'b0; start = 1'b0;
        check("startld_count", count, 1);
        run_until_idle(50);

        // start with empty buffer
        do_clr();
        pulse_start();
        check("empty_done", done, 1);
        check("empty_busy", busy, 0);
        tick(); tick();

        // randomized episodes with stalls, aborts, and ignored start/clr during replay
        for (int ep = 0; ep < 12; ep++) begin
            int n;
            do_clr();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) load($urandom_range(0, 4), 2'($urandom), 32'($urandom));
            pulse_start();
            for (int c = 0; c < 150 && busy; c++) begin
                en = ($urandom_range(0, 9) != 0);
                abort = ($urandom_range(0, 49) == 0);
                start = ($urandom_range(0, 19) == 0);
                clr = ($urandom_range(0, 19) == 0);
                tick();
                abort = 1'b0; start = 1'b0; clr = 1'b0;
            end
            en = 1'b1;
            check("rand_timeout", {63'd0, busy}, 64'd0);
            tick();
        end

`ifdef TRACE_LOOP_EN
        // continuous replay: pulses every 2 cycles, laps after each second pulse
        do_clr();
        loop = 1'b1;
        load(1, 2'b01, 32'd1); load(1, 2'b01, 32'd2);
        pulse_start();
        for (int i = 0; i < 8; i++) tick();
        check("loop_laps", laps, 16'd2);
        check("loop_done", done, 0);
        check("loop_data", in_data, 32'd2);
        for (int i = 0; i < 9; i++) tick();
        abort = 1'b1; tick(); abort = 1'b0; loop = 1'b0;
        tick();
`endif

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
